// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - data-memory arbiter with a 2-entry write buffer and read forwarding
module dram_arbiter #(
   parameter int A_WIDTH = 12,
   parameter int D_WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               r_req,
   input  logic [A_WIDTH-1:0] r_addr,
   output logic               r_ack,
   output logic               r_valid,
   output logic [D_WIDTH-1:0] r_data,
   input  logic               w_req,
   input  logic [A_WIDTH-1:0] w_addr,
   input  logic [D_WIDTH-1:0] w_data,
   output logic               w_full,
   output logic               overflow,
   output logic               mem_ce,
   output logic               mem_we,
   output logic [A_WIDTH-1:0] mem_a,
   output logic [D_WIDTH-1:0] mem_d,
   input  logic [D_WIDTH-1:0] mem_q
);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} count_t;

   count_t             count_q, count_d;
   logic [A_WIDTH-1:0] addr_q [2];
   logic [A_WIDTH-1:0] addr_d [2];
   logic [D_WIDTH-1:0] data_q [2];
   logic [D_WIDTH-1:0] data_d [2];
   logic               overflow_q, overflow_d;
   logic               r_valid_q, r_valid_d;
   logic               hit_q, hit_d;
   logic [D_WIDTH-1:0] fwd_q, fwd_d;

   logic               push, rd, drain, hit;
   logic [D_WIDTH-1:0] hit_data;
   logic [1:0]         cnt_pop;

   always_comb begin
      push  = w_req && (count_q != FULL);
      rd    = r_req && (count_q != FULL);
      drain = (count_q == FULL) || (!r_req && (count_q != EMPTY));

      // Youngest first: incoming write, then buffered entries newest to oldest.
      hit      = 1'b0;
      hit_data = '0;
      if (push && (w_addr == r_addr)) begin
         hit      = 1'b1;
         hit_data = w_data;
      end else if ((count_q == FULL) && (addr_q[1] == r_addr)) begin
         hit      = 1'b1;
         hit_data = data_q[1];
      end else if ((count_q != EMPTY) && (addr_q[0] == r_addr)) begin
         hit      = 1'b1;
         hit_data = data_q[0];
      end

      addr_d = addr_q;
      data_d = data_q;
      if (drain) begin
         addr_d[0] = addr_q[1];
         data_d[0] = data_q[1];
         addr_d[1] = '0;
         data_d[1] = '0;
      end
      // The push lands behind whatever survives this cycle's pop.
      cnt_pop = count_q - {1'b0, drain};
      if (push) begin
         addr_d[cnt_pop[0]] = w_addr;
         data_d[cnt_pop[0]] = w_data;
      end
      count_d = count_t'(cnt_pop + {1'b0, push});

      overflow_d = overflow_q || (w_req && (count_q == FULL));
      r_valid_d  = rd;
      hit_d      = rd && hit;
      fwd_d      = (rd && hit) ? hit_data : '0;

      mem_ce = 1'b0;
      mem_we = 1'b0;
      mem_a  = '0;
      mem_d  = '0;
      if (reset) begin
         if (drain) begin
            mem_ce = 1'b1;
            mem_we = 1'b1;
            mem_a  = addr_q[0];
            mem_d  = data_q[0];
         end else if (rd && !hit) begin
            mem_ce = 1'b1;
            mem_a  = r_addr;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q    <= EMPTY;
         addr_q     <= '{default: '0};
         data_q     <= '{default: '0};
         overflow_q <= 1'b0;
         r_valid_q  <= 1'b0;
         hit_q      <= 1'b0;
         fwd_q      <= '0;
      end else begin
         count_q    <= count_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         overflow_q <= overflow_d;
         r_valid_q  <= r_valid_d;
         hit_q      <= hit_d;
         fwd_q      <= fwd_d;
      end
   end

   assign r_ack    = reset && rd;
   assign w_full   = (count_q == FULL);
   assign overflow = overflow_q;
   assign r_valid  = r_valid_q;
   assign r_data   = r_valid_q ? (hit_q ? fwd_q : mem_q) : '0;

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - directed-vector bench for dram_arbiter
module tb_dram_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        r_req = 1'b0;
   logic [11:0] r_addr = '0;
   logic        r_ack, r_valid;
   logic [7:0]  r_data;
   logic        w_req = 1'b0;
   logic [11:0] w_addr = '0;
   logic [7:0]  w_data = '0;
   logic        w_full, overflow, mem_ce, mem_we;
   logic [11:0] mem_a;
   logic [7:0]  mem_d;
   logic [7:0]  mem_q = '0;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0]  mem [0:4095];
   logic [11:0] wlog_a [0:31];
   logic [7:0]  wlog_d [0:31];
   int          wlog_n = 0;
   int          n0;

   dram_arbiter #(.A_WIDTH(12), .D_WIDTH(8)) dut (
      .clk(clk), .reset(reset),
      .r_req(r_req), .r_addr(r_addr), .r_ack(r_ack), .r_valid(r_valid), .r_data(r_data),
      .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_full(w_full), .overflow(overflow),
      .mem_ce(mem_ce), .mem_we(mem_we), .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q)
   );

   always #5 clk = ~clk;

   // Synchronous RAM: read data appears one cycle after the read cycle.
   always @(posedge clk) begin
      if (mem_ce && mem_we) begin
         mem[mem_a] <= mem_d;
         if (wlog_n < 32) begin
            wlog_a[wlog_n] <= mem_a;
            wlog_d[wlog_n] <= mem_d;
         end
         wlog_n <= wlog_n + 1;
      end
      if (mem_ce && !mem_we) mem_q <= mem[mem_a];
      else                   mem_q <= 8'h00;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input logic rq, input logic [11:0] ra,
                      input logic wq, input logic [11:0] wa, input logic [7:0] wd);
      @(posedge clk);
      #1;
      r_req = rq; r_addr = ra; w_req = wq; w_addr = wa; w_data = wd;
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
      mem[12'h040] = 8'h5C;

      // Reset state, with requests present
      cyc(1'b1, 12'h040, 1'b1, 12'h123, 8'h77);
      check_eq("rst_r_ack", r_ack, 0);
      check_eq("rst_mem_ce", mem_ce, 0);
      check_eq("rst_w_full", w_full, 0);
      check_eq("rst_r_valid", r_valid, 0);
      check_eq("rst_r_data", r_data, 0);
      check_eq("rst_overflow", overflow, 0);
      @(posedge clk);
      #1;
      reset = 1'b1; r_req = 1'b0; w_req = 1'b0;
      @(negedge clk);
      check_eq("post_rst_idle_ce", mem_ce, 0);

      // Posted write drains on the following idle cycle
      cyc(1'b0, 12'h000, 1'b1, 12'h005, 8'hAA);
      check_eq("w1_no_drain_yet", mem_ce, 0);
      cyc(1'b0, 12'h000, 1'b0, 12'h000, 8'h00);
      check_eq("w1_ce", mem_ce, 1);
      check_eq("w1_we", mem_we, 1);
      check_eq("w1_a", mem_a, 12'h005);
      check_eq("w1_d", mem_d, 8'hAA);
      cyc(1'b0, 12'h000, 1'b0, 12'h000, 8'h00);
      check_eq("w1_empty_ce", mem_ce, 0);
      check_eq("w1_mem", mem[12'h005], 8'hAA);

      // Read forwarded from the write arriving in the same cycle
      cyc(1'b1, 12'h010, 1'b1, 12'h010, 8'h33);
      check_eq("fw_r_ack", r_ack, 1);
      check_eq("fw_no_mem", mem_ce, 0);
      cyc(1'b0, 12'h000, 1'b0, 12'h000, 8'h00);
      check_eq("fw_r_valid", r_valid, 1);
      check_eq("fw_r_data", r_data, 8'h33);
      check_eq("fw_drain_a", mem_a, 12'h010);
      cyc(1'b0, 12'h000, 1'b0, 12'h000, 8'h00);
      check_eq("fw_r_valid_off", r_valid, 0);
      check_eq("fw_r_data_off", r_data, 0);

      // Held read blocked while FULL, then miss returns memory data
      cyc(1'b0, 12'h000, 1'b1, 12'h030, 8'h11);
      cyc(1'b1, 12'h040, 1'b1, 12'h031, 8'h22);
      check_eq("hr_b_ack", r_ack, 1);
      check_eq("hr_b_rd_a", mem_a, 12'h040);
      check_eq("hr_b_we", mem_we, 0);
      cyc(1'b1, 12'h040, 1'b0, 12'h000, 8'h00);
      check_eq("hr_c_full", w_full, 1);
      check_eq("hr_c_ack", r_ack, 0);
      check_eq("hr_c_we", mem_we, 1);
      check_eq("hr_c_a", mem_a, 12'h030);
      check_eq("hr_c_d", mem_d, 8'h11);
      check_eq("hr_c_r_valid", r_valid, 1);
      check_eq("hr_c_r_data", r_data, 8'h5C);
      cyc(1'b1, 12'h040, 1'b0, 12'h000, 8'h00);
      check_eq("hr_d_ack", r_ack, 1);
      check_eq("hr_d_full", w_full, 0);
      check_eq("hr_d_ce", mem_ce, 1);
      check_eq("hr_d_we", mem_we, 0);
      check_eq("hr_d_a", mem_a, 12'h040);
      check_eq("hr_d_r_valid", r_valid, 0);
      cyc(1'b0, 12'h000, 1'b0, 12'h000, 8'h00);
      check_eq("hr_e_r_valid", r_valid, 1);
      check_eq("hr_e_r_data", r_data, 8'h5C);
      check_eq("hr_e_drain_a", mem_a, 12'h031);
      cyc(1'b0, 12'h000, 1'b0, 12'h000, 8'h00);
      check_eq("hr_f_idle", mem_ce, 0);

      // Third write while FULL is dropped and overflow sticks
      n0 = wlog_n;
      cyc(1'b0, 12'h000, 1'b1, 12'h050, 8'h01);
      cyc(1'b1, 12'h060, 1'b1, 12'h051, 8'h02);
      cyc(1'b0, 12'h000, 1'b1, 12'h052, 8'h03);
      check_eq("ov_full", w_full, 1);
      check_eq("ov_not_yet", overflow, 0);
      cyc(1'b0, 12'h000, 1'b0, 12'h000, 8'h00);
      check_eq("ov_set", overflow, 1);
      cyc(1'b0, 12'h000, 1'b0, 12'h000, 8'h00);
      cyc(1'b0, 12'h000, 1'b0, 12'h000, 8'h00);
      check_eq("ov_sticky", overflow, 1);
      check_eq("ov_nwrites", wlog_n - n0, 2);
      check_eq("ov_w0_a", wlog_a[n0], 12'h050);
      check_eq("ov_w1_a", wlog_a[n0+1], 12'h051);
      check_eq("ov_w1_d", wlog_d[n0+1], 8'h02);
      check_eq("ov_dropped", mem[12'h052], 8'h00);

      // Same address written twice; the younger value is forwarded
      n0 = wlog_n;
      cyc(1'b0, 12'h000, 1'b1, 12'h020, 8'h01);
      cyc(1'b1, 12'h020, 1'b1, 12'h020, 8'h02);
      check_eq("yw_ack", r_ack, 1);
      check_eq("yw_no_mem", mem_ce, 0);
      cyc(1'b0, 12'h000, 1'b0, 12'h000, 8'h00);
      check_eq("yw_r_data", r_data, 8'h02);
      check_eq("yw_drain_d0", mem_d, 8'h01);
      cyc(1'b0, 12'h000, 1'b0, 12'h000, 8'h00);
      check_eq("yw_drain_d1", mem_d, 8'h02);
      cyc(1'b0, 12'h000, 1'b0, 12'h000, 8'h00);
      check_eq("yw_order0", wlog_d[n0], 8'h01);
      check_eq("yw_order1", wlog_d[n0+1], 8'h02);
      check_eq("yw_mem", mem[12'h020], 8'h02);

      // Reset mid-operation with FULL buffer and a read in flight
      cyc(1'b0, 12'h000, 1'b1, 12'h080, 8'h0F);
      cyc(1'b1, 12'h040, 1'b1, 12'h081, 8'hF0);
      check_eq("mr_full_next", r_ack, 1);
      @(posedge clk);
      #1;
      r_req = 1'b0; w_req = 1'b0;
      #1;
      reset = 1'b0;
      n0 = wlog_n;
      #1;
      check_eq("mr_ce", mem_ce, 0);
      check_eq("mr_r_valid", r_valid, 0);
      check_eq("mr_w_full", w_full, 0);
      check_eq("mr_overflow", overflow, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      check_eq("mr_rel_ce", mem_ce, 0);
      cyc(1'b0, 12'h000, 1'b0, 12'h000, 8'h00);
      check_eq("mr_rel_ce2", mem_ce, 0);
      check_eq("mr_no_writes", wlog_n - n0, 0);
      check_eq("mr_mem80", mem[12'h080], 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 SHALL have parameter A_WIDTH, default 12: data-memory address width.
REQ-002 SHALL have parameter D_WIDTH, default 8: data-memory word width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port r_req, input, 1: read request from the fetch stage.
REQ-006 SHALL have port r_addr, input, A_WIDTH: read address, valid with r_req.
REQ-007 SHALL have port r_ack, output, 1: read accepted this cycle (combinational).
REQ-008 SHALL have port r_valid, output, 1: read data valid, registered.
REQ-009 SHALL have port r_data, output, D_WIDTH: read data, valid while r_valid is 1.
REQ-010 SHALL have port w_req, input, 1: write request from the writeback stage.
REQ-011 SHALL have port w_addr, input, A_WIDTH: write address, valid with w_req.
REQ-012 SHALL have port w_data, input, D_WIDTH: write data, valid with w_req.
REQ-013 SHALL have port w_full, output, 1: write buffer full; pushes are refused.
REQ-014 SHALL have port overflow, output, 1: sticky flag; a push was refused.
REQ-015 SHALL have port mem_ce, output, 1: memory cycle enable.
REQ-016 SHALL have port mem_we, output, 1: 1 = write, 0 = read; meaningful only while mem_ce is 1.
REQ-017 SHALL have port mem_a, output, A_WIDTH: memory address.
REQ-018 SHALL have port mem_d, output, D_WIDTH: memory write data.
REQ-019 SHALL have port mem_q, input, D_WIDTH: memory read data, valid one cycle after a read cycle.

Function
REQ-020 SHALL hold a 2-entry in-order write FIFO of {addr, data}; count takes the states EMPTY (0), ONE (1) or FULL (2).
REQ-021 SHALL drive w_full = (count == 2) from registered state only.
REQ-022 SHALL enqueue on w_req && !w_full; when w_req && w_full, the write is dropped, overflow is set to 1 and holds until reset.
REQ-023 SHALL select the memory action each cycle in this priority order: count==2 -> drain the oldest write; else r_req -> read; else count>0 -> drain the oldest write; else idle.
REQ-024 SHALL assert r_ack = r_req && (count != 2).
REQ-025 SHALL, on a drain cycle, drive mem_ce=1, mem_we=1 and present the oldest entry on mem_a/mem_d, and pop that entry at the clock edge.
REQ-026 SHALL, on an accepted read with no forwarding hit, drive mem_ce=1, mem_we=0, mem_a=r_addr, mem_d=0.
REQ-027 SHALL, on idle or a forwarded read, drive mem_ce=0, mem_we=0, mem_a=0, mem_d=0.
REQ-028 SHALL, on an accepted read, compare r_addr against the incoming write (w_req && !w_full, youngest), then the buffered entries, youngest to oldest; the first match is a hit.
REQ-029 SHALL, on a hit, register the matching data and present it on r_data with r_valid=1 on the next cycle, with no memory access.
REQ-030 SHALL, on a miss, assert r_valid=1 on the next cycle with r_data = mem_q.
REQ-031 SHALL hold r_valid=0 on every cycle not following an accepted read; r_data is then 0.
REQ-032 SHALL update count correctly when a push and a pop occur in the same cycle (net count unchanged).
REQ-033 SHALL let a drain cycle that empties the buffer and a new push in the same cycle coexist, without reordering writes.

Reset
REQ-034 SHALL, while reset=0, force asynchronously: count=EMPTY, FIFO contents=0, r_valid=0, r_data=0, overflow=0, mem_ce=0, mem_we=0, mem_a=0, mem_d=0, r_ack=0.
REQ-035 SHALL discard buffered writes and any in-flight read on reset assertion mid-operation; the first cycle after release behaves as EMPTY.

Verification
REQ-036 SHALL cover: write 0x005<-0xAA, then idle -> next cycle mem_ce=1, mem_we=1, mem_a=0x005, mem_d=0xAA; count returns to 0.
REQ-037 SHALL cover: write 0x010<-0x33 and, in the same cycle, read 0x010 -> no memory read; next cycle r_valid=1, r_data=0x33.
REQ-038 SHALL cover: two writes, then a read held on r_req -> r_ack=0 while FULL, drain 1; r_ack=1 next; miss returns preloaded mem value on r_data one cycle later.
REQ-039 SHALL cover: FULL with a third w_req -> write dropped, overflow=1 and stays 1; the memory sees only the first two writes, in order.
REQ-040 SHALL cover: reset asserted with count=2 and a read in flight -> immediate mem_ce=0, r_valid=0, w_full=0; no buffered write reaches memory after release.
REQ-041 SHALL cover: writes 0x020<-0x01 then 0x020<-0x02 buffered, read 0x020 -> r_data=0x02 (youngest wins).
